// File: rtl/t5_dmem.sv
// t5_dmem - X/M-stage load/store unit for the t5 pipeline.
//
// Decodes X-stage loads and stores, runs one Wishbone classic data cycle per
// aligned access, and holds the global pipeline enable (sena) low until that
// cycle finishes. Misaligned or illegal-width accesses never reach the bus and
// raise mmis; bus errors and timeouts end the cycle and raise mberr.
//
// Ports:
//   sclk, srst_n        clock (rising edge), asynchronous active-low reset
//   ihold               fetch-side stall request, honoured only while idle
//   xopc, xfn3          X-stage opcode [6:2] and funct3
//   xalu, xrs2          effective address and store data
//   dwb_ack, dwb_err    Wishbone slave responses
//   dwb_adr .. dwb_wre  registered Wishbone master outputs (cyc == stb)
//   xsel                combinational byte-lane select for t5_back
//   malu, mmis, mberr   M-stage ALU result, misalign flag, bus-error flag
//   sena                combinational global pipeline enable
module t5_dmem #(
    parameter int XLEN = 32,
    parameter int TOUT = 16
) (
    input  logic            sclk,
    input  logic            srst_n,
    input  logic            ihold,
    input  logic [4:0]      xopc,
    input  logic [2:0]      xfn3,
    input  logic [XLEN-1:0] xalu,
    input  logic [XLEN-1:0] xrs2,
    input  logic            dwb_ack,
    input  logic            dwb_err,
    output logic [XLEN-3:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_cyc,
    output logic            dwb_wre,
    output logic [3:0]      xsel,
    output logic [XLEN-1:0] malu,
    output logic            mmis,
    output logic            mberr,
    output logic            sena
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_REQ  = 1'b1;

    localparam int CW = $clog2(TOUT + 1);

    logic            state;
    logic [CW-1:0]   cnt;
    logic            tmo;
    logic            memop;
    logic            store;
    logic [1:0]      lane;
    logic [1:0]      a;
    logic [3:0]      sel;
    logic [XLEN-1:0] dto;
    logic            mis;
    logic            issue;
    logic            bus_end;
    logic            bus_fail;
    logic            unused_fn3;

    // funct3[2] only selects sign/zero extension, which t5_back handles.
    assign unused_fn3 = xfn3[2];

    always_comb begin
        store = (xopc == 5'b01000);
        memop = (xopc == 5'b00000) | store;
        lane  = xfn3[1:0];
        a     = xalu[1:0];
        sel   = 4'hF;
        dto   = xrs2;
        case (lane)
            2'b00: begin
                sel = 4'b0001 << a;
                dto = {4{xrs2[7:0]}};
            end
            2'b01: begin
                sel = a[1] ? 4'hC : 4'h3;
                dto = {2{xrs2[15:0]}};
            end
            default: begin
                sel = 4'hF;
                dto = xrs2;
            end
        endcase
        mis = memop & ((lane == 2'b11)
                     | ((lane == 2'b01) & a[0])
                     | ((lane == 2'b10) & (a != 2'b00)));
        xsel     = memop ? sel : 4'hF;
        issue    = (state == S_IDLE) & memop & ~mis;
        bus_end  = (state == S_REQ) & (dwb_ack | dwb_err | tmo);
        bus_fail = (state == S_REQ) & (dwb_err | tmo);
        if (!srst_n)
            sena = 1'b0;
        else if (state == S_REQ)
            sena = bus_end;
        else
            sena = ~issue & ~ihold;
    end

    assign dwb_cyc = dwb_stb;

    // The counter reaches TOUT-1 once TOUT REQ cycles have elapsed; the
    // registered tmo flag ends the cycle on the REQ cycle that follows.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state   <= S_IDLE;
            dwb_stb <= 1'b0;
            dwb_wre <= 1'b0;
            dwb_adr <= '0;
            dwb_sel <= '0;
            dwb_dto <= '0;
            cnt     <= '0;
            tmo     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state   <= S_REQ;
                        dwb_stb <= 1'b1;
                        dwb_wre <= store;
                        dwb_adr <= xalu[XLEN-1:2];
                        dwb_sel <= sel;
                        dwb_dto <= dto;
                        cnt     <= '0;
                        tmo     <= 1'b0;
                    end
                end
                default: begin
                    if (bus_end) begin
                        state   <= S_IDLE;
                        dwb_stb <= 1'b0;
                        dwb_wre <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        tmo <= (cnt == CW'(TOUT - 1));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            malu  <= '0;
            mmis  <= 1'b0;
            mberr <= 1'b0;
        end else if (sena) begin
            malu  <= xalu;
            mmis  <= mis;
            mberr <= bus_fail;
        end
    end

endmodule

// File: tb/tb_t5_dmem.sv
// tb_t5_dmem - self-checking bench for t5_dmem.
//
// A behavioural model tracks bus occupancy and the M-stage registers from the
// access rules (access size, alignment, REQ cycle count) and is compared with
// the DUT on every falling edge. Directed accesses add hand-computed checks.
module tb_t5_dmem;

    localparam int TOUT = 16;
    localparam logic [4:0] OP_ALU = 5'b00100;

    logic        sclk = 1'b0;
    logic        srst_n;
    logic        ihold;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic [31:0] xalu;
    logic [31:0] xrs2;
    logic        dwb_ack;
    logic        dwb_err;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_stb;
    logic        dwb_cyc;
    logic        dwb_wre;
    logic [3:0]  xsel;
    logic [31:0] malu;
    logic        mmis;
    logic        mberr;
    logic        sena;

    t5_dmem #(.XLEN(32), .TOUT(TOUT)) dut (
        .sclk(sclk), .srst_n(srst_n), .ihold(ihold), .xopc(xopc), .xfn3(xfn3),
        .xalu(xalu), .xrs2(xrs2), .dwb_ack(dwb_ack), .dwb_err(dwb_err),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_stb(dwb_stb), .dwb_cyc(dwb_cyc), .dwb_wre(dwb_wre), .xsel(xsel),
        .malu(malu), .mmis(mmis), .mberr(mberr), .sena(sena)
    );

    always #5 sclk = ~sclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int f_size(input logic [2:0] fn3);
        return 1 << fn3[1:0];
    endfunction

    function automatic logic f_mis(input logic [2:0] fn3, input logic [31:0] a);
        int sz = f_size(fn3);
        if (sz > 4) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    // Lanes covered by an access of the given size at its naturally aligned base.
    function automatic logic [3:0] f_sel(input logic [2:0] fn3, input logic [31:0] a);
        int sz  = f_size(fn3);
        int off = int'(a[1:0]) - (int'(a[1:0]) % sz);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] f_dto(input logic [2:0] fn3, input logic [31:0] d);
        logic [31:0] r;
        int sz = f_size(fn3);
        if (sz > 4) sz = 4;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    typedef struct {
        logic        busy;
        int          n;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dto;
        logic        wre;
        logic [31:0] malu;
        logic        mmis;
        logic        mberr;
    } mstate_t;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.busy = 0; s.n = 0; s.adr = '0; s.sel = '0; s.dto = '0; s.wre = 0;
        s.malu = '0; s.mmis = 0; s.mberr = 0;
        return s;
    endfunction

    mstate_t m  = m_reset();
    mstate_t nx = m_reset();

    always @(posedge sclk or negedge srst_n) begin
        if (!srst_n) m = m_reset();
        else         m = nx;
    end

    always @(negedge sclk) begin
        logic memop, mis, issue, fin, e_sena;
        if (!srst_n) begin
            chk("rst_stb", dwb_stb, 0);
            chk("rst_sena", sena, 0);
            nx = m_reset();
        end else begin
            memop = (xopc == 5'b00000) || (xopc == 5'b01000);
            mis   = memop && f_mis(xfn3, xalu);
            issue = 0;
            fin   = 0;
            if (!memop)                 chk("m_xsel", xsel, 4'hF);
            else if (xfn3[1:0] != 2'b11) chk("m_xsel", xsel, f_sel(xfn3, xalu));
            if (!m.busy) begin
                issue  = memop && !mis;
                e_sena = issue ? 1'b0 : !ihold;
                chk("m_stb", dwb_stb, 0);
                chk("m_wre", dwb_wre, 0);
            end else begin
                fin    = dwb_ack || dwb_err || (m.n == TOUT);
                e_sena = fin;
                chk("m_stb", dwb_stb, 1);
                chk("m_adr", dwb_adr, m.adr);
                chk("m_sel", dwb_sel, m.sel);
                chk("m_dto", dwb_dto, m.dto);
                chk("m_wre", dwb_wre, m.wre);
            end
            chk("m_cyc", dwb_cyc, dwb_stb);
            chk("m_sena", sena, e_sena);
            chk("m_malu", malu, m.malu);
            chk("m_mmis", mmis, m.mmis);
            chk("m_mberr", mberr, m.mberr);
            nx = m;
            if (issue) begin
                nx.busy = 1; nx.n = 0;
                nx.adr = xalu[31:2];
                nx.sel = f_sel(xfn3, xalu);
                nx.dto = f_dto(xfn3, xrs2);
                nx.wre = (xopc == 5'b01000);
            end else if (m.busy) begin
                if (fin) nx.busy = 0;
                else     nx.n = m.n + 1;
            end
            if (e_sena) begin
                nx.malu  = xalu;
                nx.mmis  = mis;
                nx.mberr = m.busy && (dwb_err || (m.n == TOUT));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [29:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dto;
    logic        s_wre, s_stb;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Presents one mem op and counts cycles with sena low until it retires.
    task automatic access(input logic [4:0] opc, input logic [2:0] fn3,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input int ack_at, input int err_at, output int low);
        xopc = opc; xfn3 = fn3; xalu = alu; xrs2 = rs2;
        low = 0;
        for (int k = 0; k < 40; k++) begin
            dwb_ack = (k == ack_at);
            dwb_err = (k == err_at);
            #3;
            if (k == 1) begin
                s_adr = dwb_adr; s_sel = dwb_sel; s_dto = dwb_dto;
                s_wre = dwb_wre; s_stb = dwb_stb;
            end
            if (sena) break;
            low++;
            step();
        end
        step();
        dwb_ack = 0; dwb_err = 0; xopc = OP_ALU;
    endtask

    initial begin
        int low;
        srst_n = 0; ihold = 0; xopc = OP_ALU; xfn3 = 0; xalu = 32'h1234;
        xrs2 = 0; dwb_ack = 0; dwb_err = 0;
        repeat (2) @(posedge sclk);
        #1;
        chk("reset_stb", dwb_stb, 0);
        chk("reset_sena", sena, 0);
        chk("reset_malu", malu, 0);
        chk("reset_adr", dwb_adr, 0);
        chk("reset_sel", dwb_sel, 0);
        chk("reset_mberr", mberr, 0);
        srst_n = 1;
        #3 chk("alu_sena", sena, 1);
        step();

        // LW 0x100, ack on first REQ cycle
        access(5'b00000, 3'b010, 32'h100, 0, 1, -1, low);
        chk("lw_low", low, 1);
        chk("lw_adr", s_adr, 30'h40);
        chk("lw_sel", s_sel, 4'hF);
        chk("lw_wre", s_wre, 0);
        chk("lw_stb", s_stb, 1);
        #3 chk("lw_malu", malu, 32'h100);
        chk("lw_stb_off", dwb_stb, 0);
        step();

        // SB 0x203, ack on fourth REQ cycle
        access(5'b01000, 3'b000, 32'h203, 32'hA5, 4, -1, low);
        chk("sb_low", low, 4);
        chk("sb_sel", s_sel, 4'h8);
        chk("sb_dto", s_dto, 32'hA5A5A5A5);
        chk("sb_wre", s_wre, 1);
        step();

        // SH 0x702: upper half lanes
        access(5'b01000, 3'b001, 32'h702, 32'h1234BEEF, 1, -1, low);
        chk("sh_sel", s_sel, 4'hC);
        chk("sh_dto", s_dto, 32'hBEEFBEEF);
        step();

        // LH misaligned
        xopc = 5'b00000; xfn3 = 3'b001; xalu = 32'h101;
        #3 chk("lh_mis_xsel", xsel, 4'h3);
        chk("lh_mis_sena", sena, 1);
        step();
        xopc = OP_ALU;
        #3 chk("lh_mis_mmis", mmis, 1);
        chk("lh_mis_stb", dwb_stb, 0);
        step();

        // illegal width load
        xopc = 5'b00000; xfn3 = 3'b011; xalu = 32'h400;
        #3 chk("ill_sena", sena, 1);
        step();
        xopc = OP_ALU;
        #3 chk("ill_mmis", mmis, 1);
        step();

        // load timeout
        access(5'b00000, 3'b010, 32'h500, 0, -1, -1, low);
        chk("tmo_low", low, 17);
        #3 chk("tmo_mberr", mberr, 1);
        chk("tmo_stb", dwb_stb, 0);
        step();
        #3 chk("tmo_mberr_clear", mberr, 0);
        step();

        // bus error on second REQ cycle
        access(5'b00000, 3'b010, 32'h500, 0, -1, 2, low);
        chk("err_low", low, 2);
        #3 chk("err_mberr", mberr, 1);
        step();

        // ack and err together count as error
        access(5'b01000, 3'b010, 32'h600, 32'h11223344, 1, 1, low);
        chk("ackerr_low", low, 1);
        #3 chk("ackerr_mberr", mberr, 1);
        step();

        // ihold gates ALU ops but not the ack cycle
        ihold = 1;
        #3 chk("ihold_alu", sena, 0);
        step();
        access(5'b00000, 3'b010, 32'h104, 0, 2, -1, low);
        chk("ihold_ack_low", low, 2);
        #3 chk("ihold_after", sena, 0);
        ihold = 0;
        step();

        // asynchronous reset in the middle of a request
        xopc = 5'b01000; xfn3 = 3'b010; xalu = 32'h300; xrs2 = 32'hCAFE;
        step();
        #1 chk("arst_pre_stb", dwb_stb, 1);
        #1 srst_n = 0;
        #1 chk("arst_stb", dwb_stb, 0);
        chk("arst_cyc", dwb_cyc, 0);
        chk("arst_sena", sena, 0);
        xopc = OP_ALU;
        step();
        step();
        srst_n = 1;
        #3 chk("arst_idle_sena", sena, 1);
        chk("arst_idle_stb", dwb_stb, 0);
        step();
        #3 chk("arst_noretry", dwb_stb, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
